// File: rtl/load_store_unit_pkg.sv
// ============================================================================
//  Module      : common (package)
//  Description : RV32I load/store funct3 encodings, LSU state type and the
//                alignment legality check shared by the load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package common;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;
    localparam logic [2:0] c_F3_SB  = 3'b000;
    localparam logic [2:0] c_F3_SH  = 3'b001;
    localparam logic [2:0] c_F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // Unlisted funct3 encodings are rejected the same way as bad alignment.
    function automatic logic lsu_misaligned(input logic       is_store,
                                            input logic [2:0] funct3,
                                            input logic [1:0] byte_offset);
        logic bad;
        bad = 1'b1;
        if (is_store) begin
            case (funct3)
                c_F3_SB: bad = 1'b0;
                c_F3_SH: bad = byte_offset[0];
                c_F3_SW: bad = |byte_offset;
                default: bad = 1'b1;
            endcase
        end else begin
            case (funct3)
                c_F3_LB, c_F3_LBU: bad = 1'b0;
                c_F3_LH, c_F3_LHU: bad = byte_offset[0];
                c_F3_LW:           bad = |byte_offset;
                default:           bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational lane handling: load extract/extend and store
//                lane merge into the previously read word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
    import common::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_offset,
    input  logic [31:0] read_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte    = read_word[{byte_offset, 3'b000} +: 8];
        w_half    = read_word[{byte_offset[1], 4'b0000} +: 16];
        load_data = '0;
        case (funct3)
            c_F3_LB:  load_data = {{24{w_byte[7]}}, w_byte};
            c_F3_LH:  load_data = {{16{w_half[15]}}, w_half};
            c_F3_LW:  load_data = read_word;
            c_F3_LBU: load_data = {24'd0, w_byte};
            c_F3_LHU: load_data = {16'd0, w_half};
            default:  load_data = '0;
        endcase
    end

    always_comb begin
        merged_word = read_word;
        case (funct3)
            c_F3_SB: merged_word[{byte_offset, 3'b000} +: 8]     = store_data[7:0];
            c_F3_SH: merged_word[{byte_offset[1], 4'b0000} +: 16] = store_data[15:0];
            c_F3_SW: merged_word = store_data;
            default: merged_word = read_word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
//  Module      : load_store_unit
//  Description : RV32I byte/half/word load-store unit in front of a word
//                memory; sub-word stores use read-modify-write.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import common::*;
#(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_misaligned,
    output logic                     mem_write_en,
    output logic [ADDRESS_WIDTH+1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    input  logic [DATA_WIDTH-1:0]    mem_read_data
);

    lsu_state_t               r_state;
    lsu_state_t               w_next_state;
    logic                     r_write;
    logic [2:0]               r_funct3;
    logic [ADDRESS_WIDTH+1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_word;
    logic                     r_misaligned;
    logic                     w_handshake;
    logic                     w_req_misaligned;
    logic [DATA_WIDTH-1:0]    w_load_data;
    logic [DATA_WIDTH-1:0]    w_merged_word;

    assign req_ready        = (r_state == IDLE);
    assign w_handshake      = req_valid && req_ready;
    assign w_req_misaligned = lsu_misaligned(req_write, req_funct3, req_addr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_handshake) begin
                    if (w_req_misaligned)                           w_next_state = RESP;
                    else if (req_write && req_funct3 == c_F3_SW)    w_next_state = WRITE;
                    else                                            w_next_state = READ;
                end
            end
            READ:    w_next_state = r_write ? WRITE : RESP;
            WRITE:   w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write      <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_word       <= '0;
            r_misaligned <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_write      <= req_write;
                r_funct3     <= req_funct3;
                r_addr       <= req_addr;
                r_wdata      <= req_wdata;
                r_misaligned <= w_req_misaligned;
            end
            if (r_state == READ) r_word <= mem_read_data;
        end
    end

    lsu_align u_align (
        .funct3      (r_funct3),
        .byte_offset (r_addr[1:0]),
        .read_word   (r_word),
        .store_data  (r_wdata),
        .load_data   (w_load_data),
        .merged_word (w_merged_word)
    );

    // Memory-side outputs are held at zero outside the states that use them.
    assign mem_write_en    = (r_state == WRITE);
    assign mem_write_data  = (r_state == WRITE) ? w_merged_word : '0;
    assign mem_address     = (r_state == READ || r_state == WRITE)
                           ? {r_addr[ADDRESS_WIDTH+1:2], 2'b00} : '0;

    assign resp_valid      = (r_state == RESP);
    assign resp_misaligned = (r_state == RESP) && r_misaligned;
    assign resp_rdata      = (r_state == RESP && !r_write && !r_misaligned) ? w_load_data : '0;

endmodule

`default_nettype wire
